ia_compressor: RTL and testbench

IA_COMPRESSOR -- requirements
Module: ia_compressor

---
 rtl/ia_compressor_pkg.sv | 9 +
 rtl/ia_compressor_if.sv | 36 +++
 rtl/ia_compressor.sv | 104 ++++++++++
 tb/tb_ia_compressor.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ia_compressor_pkg.sv
// ia_compressor_pkg: shared sizing constants and FSM state encoding for the compressor and PE
package ia_compressor_pkg;
  localparam int DEF_IA_CHANNEL = 32;
  localparam int DEF_IA_DATA_BITWIDTH = 8;
  localparam int DEF_IA_C_BITWIDTH = $clog2(DEF_IA_CHANNEL);
  localparam int DEF_IA_ROW = 32;
  localparam int DEF_IA_COL = 32;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RELEASE} ia_state_e;
endpackage

// File: rtl/ia_compressor_if.sv
// ia_compressor_if: dense activation stream in, packed sparse vector and PE handshake out
interface ia_compressor_if
  import ia_compressor_pkg::*;
#(
  parameter int IA_CHANNEL = DEF_IA_CHANNEL,
  parameter int IA_DATA_BITWIDTH = DEF_IA_DATA_BITWIDTH,
  parameter int IA_C_BITWIDTH = DEF_IA_C_BITWIDTH,
  parameter int IA_ROW = DEF_IA_ROW,
  parameter int IA_COL = DEF_IA_COL
);
  localparam int LW = $clog2(IA_CHANNEL) + 1;
  localparam int HW = $clog2(IA_ROW) + 1;
  localparam int WW = $clog2(IA_COL) + 1;
  logic i_valid;
  logic o_ready;
  logic [IA_DATA_BITWIDTH-1:0] i_data;
  logic [HW-1:0] i_h;
  logic [WW-1:0] i_w;
  logic [IA_CHANNEL-1:0][IA_DATA_BITWIDTH-1:0] o_ia_data;
  logic [IA_CHANNEL-1:0][IA_C_BITWIDTH-1:0] o_ia_c_idx;
  logic [LW-1:0] o_ia_len;
  logic [LW-1:0] o_ia_iters;
  logic [HW-1:0] o_ia_h;
  logic [WW-1:0] o_ia_w;
  logic o_pe_start;
  logic i_pe_finish;
  logic o_done;
  modport slave (
    input i_valid, i_data, i_h, i_w, i_pe_finish,
    output o_ready, o_ia_data, o_ia_c_idx, o_ia_len, o_ia_iters, o_ia_h, o_ia_w, o_pe_start, o_done
  );
  modport master (
    output i_valid, i_data, i_h, i_w, i_pe_finish,
    input o_ready, o_ia_data, o_ia_c_idx, o_ia_len, o_ia_iters, o_ia_h, o_ia_w, o_pe_start, o_done
  );
endinterface

// File: rtl/ia_compressor.sv
// ia_compressor: packs the nonzero channels of a dense activation vector and hands it to a PE
module ia_compressor
  import ia_compressor_pkg::*;
#(
  parameter int IA_CHANNEL = DEF_IA_CHANNEL,
  parameter int IA_DATA_BITWIDTH = DEF_IA_DATA_BITWIDTH,
  parameter int IA_C_BITWIDTH = DEF_IA_C_BITWIDTH,
  parameter int IA_ROW = DEF_IA_ROW,
  parameter int IA_COL = DEF_IA_COL
) (
  input logic i_clk,
  input logic i_rst_n,
  ia_compressor_if.slave bus
);
  localparam int LW = $clog2(IA_CHANNEL) + 1;
  localparam int HW = $clog2(IA_ROW) + 1;
  localparam int WW = $clog2(IA_COL) + 1;
  ia_state_e state_q, state_d;
  logic [LW-1:0] ch_q, ch_d, len_q, len_d, cur_ch;
  logic [IA_CHANNEL-1:0][IA_DATA_BITWIDTH-1:0] data_q, data_d;
  logic [IA_CHANNEL-1:0][IA_C_BITWIDTH-1:0] idx_q, idx_d;
  logic [HW-1:0] h_q, h_d;
  logic [WW-1:0] w_q, w_d;
  logic start_q, start_d, done_q, done_d;
  logic ready, accept, last, nz;
  assign ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept = bus.i_valid && ready;
  assign nz = bus.i_data != '0;
  assign cur_ch = (state_q == S_IDLE) ? '0 : ch_q;
  assign last = cur_ch == LW'(IA_CHANNEL - 1);
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    len_d = len_q;
    data_d = data_q;
    idx_d = idx_q;
    h_d = h_q;
    w_d = w_q;
    done_d = 1'b0;
    if (accept) begin
      if (state_q == S_IDLE) begin
        data_d = '0;
        idx_d = '0;
        len_d = '0;
        h_d = bus.i_h;
        w_d = bus.i_w;
      end
      if (nz && len_d < LW'(IA_CHANNEL)) begin
        for (int k = 0; k < IA_CHANNEL; k++) begin
          if (k == int'(len_d)) begin
            data_d[k] = bus.i_data;
            idx_d[k] = IA_C_BITWIDTH'(cur_ch);
          end
        end
        len_d = len_d + 1'b1;
      end
      ch_d = cur_ch + 1'b1;
      state_d = S_LOAD;
      if (last) begin
        ch_d = '0;
        state_d = (len_d != '0) ? S_RUN : S_IDLE;
        done_d = len_d == '0;
      end
    end else if (state_q == S_RUN && bus.i_pe_finish) begin
      state_d = S_RELEASE;
    end else if (state_q == S_RELEASE && !bus.i_pe_finish) begin
      state_d = S_IDLE;
      done_d = 1'b1;
    end
    start_d = state_d == S_RUN;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ch_q <= '0;
      len_q <= '0;
      data_q <= '0;
      idx_q <= '0;
      h_q <= '0;
      w_q <= '0;
      start_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      len_q <= len_d;
      data_q <= data_d;
      idx_q <= idx_d;
      h_q <= h_d;
      w_q <= w_d;
      start_q <= start_d;
      done_q <= done_d;
    end
  end
  assign bus.o_ready = ready;
  assign bus.o_ia_data = data_q;
  assign bus.o_ia_c_idx = idx_q;
  assign bus.o_ia_len = len_q;
  assign bus.o_ia_iters = '0;
  assign bus.o_ia_h = h_q;
  assign bus.o_ia_w = w_q;
  assign bus.o_pe_start = start_q;
  assign bus.o_done = done_q;
endmodule

// File: tb/tb_ia_compressor.sv
// tb_ia_compressor: directed and random vectors checked against a queue-based compression model
module tb_ia_compressor;
  typedef logic [7:0] vec_t [8];
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int passed = 0;
  ia_compressor_if #(.IA_CHANNEL(8), .IA_DATA_BITWIDTH(8), .IA_C_BITWIDTH(3), .IA_ROW(32), .IA_COL(32)) bus ();
  ia_compressor #(.IA_CHANNEL(8), .IA_DATA_BITWIDTH(8), .IA_C_BITWIDTH(3), .IA_ROW(32), .IA_COL(32)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic chk_vec(input string tag, input vec_t ed, input logic [2:0] ei [8], input int el, input int h, input int w);
    chk({tag, "_len"}, 32'(bus.o_ia_len), 32'(el));
    chk({tag, "_h"}, 32'(bus.o_ia_h), 32'(h));
    chk({tag, "_w"}, 32'(bus.o_ia_w), 32'(w));
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_data%0d", tag, k), 32'(bus.o_ia_data[k]), 32'(ed[k]));
      chk($sformatf("%s_idx%0d", tag, k), 32'(bus.o_ia_c_idx[k]), 32'(ei[k]));
    end
  endtask
  task automatic run_vec(input string tag, input vec_t v, input int h, input int w, input bit gap);
    logic [7:0] qd[$];
    logic [2:0] qc[$];
    vec_t ed;
    logic [2:0] ei [8];
    int el;
    for (int c = 0; c < 8; c++) if (v[c] != 8'h00) begin
      qd.push_back(v[c]);
      qc.push_back(3'(c));
    end
    el = qd.size();
    for (int k = 0; k < 8; k++) begin
      ed[k] = (k < el) ? qd[k] : 8'h00;
      ei[k] = (k < el) ? qc[k] : 3'd0;
    end
    for (int c = 0; c < 8; c++) begin
      if (gap) begin
        bus.i_valid = 1'b0;
        @(negedge clk);
      end
      chk({tag, "_ready_load"}, 32'(bus.o_ready), 32'd1);
      chk({tag, "_nostart_load"}, 32'(bus.o_pe_start), 32'd0);
      bus.i_valid = 1'b1;
      bus.i_data = v[c];
      bus.i_pe_finish = 1'($urandom);
      bus.i_h = (c == 0) ? 6'(h) : 6'($urandom);
      bus.i_w = (c == 0) ? 6'(w) : 6'($urandom);
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    bus.i_pe_finish = 1'b0;
    chk({tag, "_start"}, 32'(bus.o_pe_start), 32'(el > 0));
    chk({tag, "_done"}, 32'(bus.o_done), 32'(el == 0));
    chk_vec(tag, ed, ei, el, h, w);
    if (el == 0) begin
      @(negedge clk);
      chk({tag, "_done_once"}, 32'(bus.o_done), 32'd0);
      chk({tag, "_start_idle"}, 32'(bus.o_pe_start), 32'd0);
      chk({tag, "_ready_idle"}, 32'(bus.o_ready), 32'd1);
    end else begin
      repeat (4) begin
        chk({tag, "_start_run"}, 32'(bus.o_pe_start), 32'd1);
        chk({tag, "_ready_run"}, 32'(bus.o_ready), 32'd0);
        chk({tag, "_len_run"}, 32'(bus.o_ia_len), 32'(el));
        chk({tag, "_d0_run"}, 32'(bus.o_ia_data[0]), 32'(ed[0]));
        @(negedge clk);
      end
      bus.i_pe_finish = 1'b1;
      @(negedge clk);
      chk({tag, "_start_fall"}, 32'(bus.o_pe_start), 32'd0);
      chk({tag, "_ready_rel"}, 32'(bus.o_ready), 32'd0);
      chk({tag, "_done_rel"}, 32'(bus.o_done), 32'd0);
      @(negedge clk);
      chk({tag, "_ready_rel2"}, 32'(bus.o_ready), 32'd0);
      bus.i_pe_finish = 1'b0;
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(bus.o_done), 32'd1);
      chk({tag, "_ready_idle"}, 32'(bus.o_ready), 32'd1);
      chk({tag, "_start_idle"}, 32'(bus.o_pe_start), 32'd0);
      @(negedge clk);
      chk({tag, "_done_once"}, 32'(bus.o_done), 32'd0);
      chk_vec({tag, "_held"}, ed, ei, el, h, w);
    end
  endtask
  initial begin
    vec_t v;
    vec_t z;
    logic [2:0] zi [8];
    for (int k = 0; k < 8; k++) begin
      z[k] = 8'h00;
      zi[k] = 3'd0;
    end
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data = 8'h00;
    bus.i_h = '0;
    bus.i_w = '0;
    bus.i_pe_finish = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_start", 32'(bus.o_pe_start), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_iters", 32'(bus.o_ia_iters), 32'd0);
    chk_vec("rst", z, zi, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{8'h00, 8'h03, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h07};
    run_vec("basic", v, 1, 2, 1'b0);
    run_vec("zeros", z, 5, 6, 1'b0);
    v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_vec("full", v, 31, 32, 1'b0);
    v = '{8'h00, 8'h03, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h07};
    run_vec("gap", v, 1, 2, 1'b1);
    for (int t = 0; t < 20; t++) begin
      foreach (v[c]) v[c] = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
      run_vec($sformatf("rnd%0d", t), v, int'($urandom_range(32)), int'($urandom_range(32)), 1'($urandom));
    end
    v = '{8'h11, 8'h00, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    for (int c = 0; c < 4; c++) begin
      bus.i_valid = 1'b1;
      bus.i_data = v[c];
      bus.i_h = 6'd9;
      bus.i_w = 6'd10;
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.o_ready), 32'd1);
    chk("midrst_start", 32'(bus.o_pe_start), 32'd0);
    chk("midrst_done", 32'(bus.o_done), 32'd0);
    chk_vec("midrst", z, zi, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec("after_rst", v, 3, 4, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
